// File: rtl/merge_rr.sv
// Round-robin N-to-1 native-bus merger: arbitrates once per transaction, holds the
// registered grant until the slave returns ready, then spends one IDLE cycle re-arbitrating.
module merge_rr #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int unsigned RESP_W   = DATA_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp
);

  localparam int unsigned GW = $clog2(N_MASTERS);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   last_q;
  logic [GW-1:0]   winner;
  logic [GW:0]     cand;
  logic [N_MASTERS-1:0] valid;
  logic            any_valid;

  always_comb begin
    valid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      valid[i] = m_req[i*REQ_W + REQ_W - 1];
    end
  end

  // Walk candidates from farthest to nearest after last, so the nearest valid one wins.
  always_comb begin
    winner    = last_q;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      cand = {1'b0, last_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_MASTERS)) begin
        cand = cand - (GW+1)'(N_MASTERS);
      end
      if (valid[cand[GW-1:0]]) begin
        winner    = cand[GW-1:0];
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GW'(N_MASTERS - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            grant_q <= winner;
            last_q  <= winner;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (s_resp[0]) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Both paths are muxed only by registered state, so reset clears them without a clock.
  always_comb begin
    s_req  = '0;
    m_resp = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (state_q == StBusy && grant_q == GW'(i)) begin
        s_req                      = m_req[i*REQ_W +: REQ_W];
        m_resp[i*RESP_W +: RESP_W] = s_resp;
      end
    end
  end

endmodule

// File: tb/tb_merge_rr.sv
// Bench for merge_rr: a transaction-level arbitration model checked every cycle on a
// 2-master and a 3-master instance, plus directed scenarios with literal expectations.
module tb_merge_rr;

  localparam int RW = 69;
  localparam int SW = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [2*RW-1:0] m_req2  = '0;
  logic [2*SW-1:0] m_resp2;
  logic [RW-1:0]   s_req2;
  logic [SW-1:0]   s_resp2 = '0;
  logic [3*RW-1:0] m_req3  = '0;
  logic [3*SW-1:0] m_resp3;
  logic [RW-1:0]   s_req3;
  logic [SW-1:0]   s_resp3 = '0;

  int checks = 0;
  int passes = 0;
  int served2[$];
  int served3[$];

  merge_rr #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut2 (
    .clk(clk), .rst(rst), .m_req(m_req2), .m_resp(m_resp2), .s_req(s_req2), .s_resp(s_resp2)
  );

  merge_rr #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32)) dut3 (
    .clk(clk), .rst(rst), .m_req(m_req3), .m_resp(m_resp3), .s_req(s_req3), .s_resp(s_resp3)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] req(logic v, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    return {v, a, d, s};
  endfunction

  // First valid master at or after last+1, wrapping; -1 when nobody requests.
  function automatic int pick(logic [2:0] v, int last, int n);
    int r;
    r = -1;
    for (int k = 1; k <= n; k++) begin
      int j;
      j = (last + k) % n;
      if (r < 0 && v[j]) r = j;
    end
    return r;
  endfunction

  function automatic int at2(int i);
    if (i < served2.size()) return served2[i];
    return -1;
  endfunction

  function automatic int at3(int i);
    if (i < served3.size()) return served3[i];
    return -1;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
  endtask

  // Transaction-level model: who owns the slave, and whose turn it was last.
  logic [2:0] v2, v3;
  int p2, p3;
  logic b2 = 1'b0;
  logic b3 = 1'b0;
  int g2 = 0;
  int g3 = 0;
  int l2 = 1;
  int l3 = 2;
  logic [RW-1:0]   es2, es3;
  logic [2*SW-1:0] em2;
  logic [3*SW-1:0] em3;

  always_comb begin
    v2 = '0;
    v3 = '0;
    for (int i = 0; i < 2; i++) v2[i] = m_req2[i*RW + RW - 1];
    for (int i = 0; i < 3; i++) v3[i] = m_req3[i*RW + RW - 1];
    p2 = pick(v2, l2, 2);
    p3 = pick(v3, l3, 3);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b2 <= 1'b0; g2 <= 0; l2 <= 1;
      b3 <= 1'b0; g3 <= 0; l3 <= 2;
    end else begin
      if (!b2) begin
        if (p2 >= 0) begin b2 <= 1'b1; g2 <= p2; l2 <= p2; end
      end else if (s_resp2[0]) b2 <= 1'b0;
      if (!b3) begin
        if (p3 >= 0) begin b3 <= 1'b1; g3 <= p3; l3 <= p3; end
      end else if (s_resp3[0]) b3 <= 1'b0;
    end
  end

  always_comb begin
    es2 = '0; em2 = '0; es3 = '0; em3 = '0;
    for (int i = 0; i < 2; i++) begin
      if (b2 && g2 == i) begin es2 = m_req2[i*RW +: RW]; em2[i*SW +: SW] = s_resp2; end
    end
    for (int i = 0; i < 3; i++) begin
      if (b3 && g3 == i) begin es3 = m_req3[i*RW +: RW]; em3[i*SW +: SW] = s_resp3; end
    end
  end

  always @(negedge clk) begin
    check("s_req2", s_req2, es2);
    check("m_resp2", m_resp2, em2);
    check("s_req3", s_req3, es3);
    check("m_resp3", m_resp3, em3);
    for (int i = 0; i < 2; i++) if (m_resp2[i*SW]) served2.push_back(i);
    for (int i = 0; i < 3; i++) if (m_resp3[i*SW]) served3.push_back(i);
  end

  task automatic wait_valid(input bit sel, output int t);
    t = 0;
    while (!(sel ? s_req3[RW-1] : s_req2[RW-1]) && t < 40) begin
      @(posedge clk); #1; t++;
    end
    check("wait_valid", (t < 40), 1);
  endtask

  // Slave answering lat cycles after the first valid cycle; the request must not move meanwhile.
  task automatic respond(input bit sel, input int lat, input logic [31:0] rd);
    logic [RW-1:0] held;
    held = sel ? s_req3 : s_req2;
    repeat (lat) begin
      @(posedge clk); #1;
      check("s_req_hold", sel ? s_req3 : s_req2, held);
    end
    if (sel) s_resp3 = {rd, 1'b1};
    else     s_resp2 = {rd, 1'b1};
    @(posedge clk); #1;
    s_resp2 = '0;
    s_resp3 = '0;
  endtask

  task automatic serve(input bit sel, input int lat, input logic [31:0] rd, output int t);
    wait_valid(sel, t);
    respond(sel, lat, rd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual still running at 100000, required $finish earlier");
    $fatal(1);
  end

  initial begin
    int t, n0, n1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_s_req2", s_req2, 0);
    check("rst_m_resp2", m_resp2, 0);

    // Single master 1 read with a 1-cycle slave.
    served2.delete();
    m_req2[RW +: RW] = req(1'b1, 32'h100, 32'h0, 4'h0);
    #1 check("t1_not_yet", s_req2[RW-1], 0);
    @(posedge clk); #1;
    check("t1_valid_rises", s_req2, req(1'b1, 32'h100, 32'h0, 4'h0));
    @(posedge clk); #1;
    s_resp2 = {32'hDEADBEEF, 1'b1};
    #1;
    check("t1_m_resp1", m_resp2[SW +: SW], {32'hDEADBEEF, 1'b1});
    check("t1_m_resp0", m_resp2[0 +: SW], 0);
    @(posedge clk); #1;
    s_resp2 = '0;
    m_req2  = '0;
    check("t1_served", at2(0), 1);

    // Simultaneous requests straight out of reset.
    do_reset();
    served2.delete();
    m_req2 = {req(1'b1, 32'h204, 32'hA5A5A5A5, 4'hF), req(1'b1, 32'h200, 32'h0, 4'h0)};
    serve(1'b0, 1, 32'h1, t);
    check("t2_latency", t, 1);
    m_req2[0 +: RW] = '0;
    serve(1'b0, 1, 32'h2, t);
    check("t2_idle_gap", t, 1);
    m_req2 = '0;
    check("t2_first", at2(0), 0);
    check("t2_second", at2(1), 1);

    // Fairness under saturation.
    served2.delete();
    m_req2 = {req(1'b1, 32'h300, 32'h0, 4'h0), req(1'b1, 32'h400, 32'h0, 4'h0)};
    for (int k = 0; k < 8; k++) serve(1'b0, 1, 32'h100 + k, t);
    m_req2 = '0;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < served2.size(); k++) if (served2[k] == 0) n0++; else n1++;
    for (int k = 0; k < 8; k++) check("t3_order", at2(k), k % 2);
    check("t3_count0", n0, 4);
    check("t3_count1", n1, 4);

    // Slow slave; master 1 arrives while master 0 owns the bus.
    served2.delete();
    m_req2[0 +: RW] = req(1'b1, 32'h500, 32'h11223344, 4'hF);
    wait_valid(1'b0, t);
    m_req2[RW +: RW] = req(1'b1, 32'h600, 32'h0, 4'h0);
    check("t4_owner", s_req2, req(1'b1, 32'h500, 32'h11223344, 4'hF));
    respond(1'b0, 5, 32'h0);
    m_req2[0 +: RW] = '0;
    serve(1'b0, 1, 32'h77, t);
    m_req2 = '0;
    check("t4_first", at2(0), 0);
    check("t4_next", at2(1), 1);

    // Reset in the second BUSY cycle of a master-0 transaction.
    served2.delete();
    m_req2[0 +: RW] = req(1'b1, 32'h700, 32'h0, 4'h0);
    wait_valid(1'b0, t);
    @(posedge clk); #1;
    s_resp2 = {32'hCAFEF00D, 1'b0};
    #1 check("t5_pre_m_resp0", m_resp2[0 +: SW], {32'hCAFEF00D, 1'b0});
    rst = 1'b1;
    #1;
    check("t5_rst_s_req", s_req2, 0);
    check("t5_rst_m_resp", m_resp2, 0);
    s_resp2 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_req2 = {req(1'b1, 32'h710, 32'h0, 4'h0), req(1'b1, 32'h720, 32'h0, 4'h0)};
    serve(1'b0, 1, 32'h5, t);
    m_req2 = '0;
    check("t5_winner", at2(0), 0);
    check("t5_count", served2.size(), 1);

    // Three masters, 1 idle: grant skips it; stray ready in IDLE goes nowhere.
    served3.delete();
    m_req3 = {req(1'b1, 32'h820, 32'h0, 4'h0), {RW{1'b0}}, req(1'b1, 32'h800, 32'h0, 4'h0)};
    for (int k = 0; k < 4; k++) serve(1'b1, 1, 32'h900 + k, t);
    m_req3 = '0;
    check("t6_g0", at3(0), 0);
    check("t6_g1", at3(1), 2);
    check("t6_g2", at3(2), 0);
    check("t6_g3", at3(3), 2);
    s_resp3 = {32'h12345678, 1'b1};
    #1;
    check("t6_stray_m_resp", m_resp3, 0);
    check("t6_stray_s_req", s_req3, 0);
    @(posedge clk); #1;
    s_resp3 = '0;
    check("t6_stray_served", served3.size(), 4);
    m_req3[RW +: RW] = req(1'b1, 32'h810, 32'h0, 4'h0);
    serve(1'b1, 2, 32'hAB, t);
    m_req3 = '0;
    check("t6_after_stray", at3(4), 1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
